// File: rtl/multicycle_controller.sv
// Multicycle instruction controller: sequences fetch, decode, execute,
// memory and write-back for a non-pipelined core, with a bounded wait on
// each memory handshake and a sticky fault state.
module multicycle_controller #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic [1:0]  read_status,
    input  logic [1:0]  write_status,
    input  logic [1:0]  write_back_type,
    input  logic        change_branch_instruction,
    input  logic        branch_taken,
    input  logic        illegal_instruction,
    output logic        imem_req,
    output logic        ir_write,
    output logic        dmem_req,
    output logic        dmem_write,
    output logic        rf_write,
    output logic        pc_write,
    output logic        pc_source,
    output logic        fault,
    output logic [2:0]  state,
    output logic [31:0] retired_count
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_FAULT     = 3'd7
    } state_t;

    localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wait_q;
    logic [7:0] wait_d;
    logic [8:0] wait_inc;
    logic       started;
    logic       is_load;
    logic       is_store;
    logic       is_jal;
    logic       is_branch;
    logic       taken;

    // Kept separate from the state code so that state can read FETCH while
    // every strobe stays low until the first edge after reset release.
    // started marks that first edge.

    // State, wait counter, captured decode flags and retirement counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_FETCH;
            wait_q        <= '0;
            started       <= 1'b0;
            is_load       <= 1'b0;
            is_store      <= 1'b0;
            is_jal        <= 1'b0;
            is_branch     <= 1'b0;
            taken         <= 1'b0;
            retired_count <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            started <= 1'b1;
            if (state_q == S_EXECUTE) begin
                is_load   <= (read_status != 2'b00);
                is_store  <= (write_status != 2'b00);
                is_jal    <= (write_back_type == 2'd2);
                is_branch <= change_branch_instruction;
                taken     <= branch_taken;
            end
            if (state_q == S_WRITEBACK) begin
                retired_count <= retired_count + 32'd1;
            end
        end
    end

    // Next-state and wait-counter logic; a ready in the timeout cycle wins.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        wait_inc = {1'b0, wait_q} + 9'd1;
        case (state_q)
            S_FETCH: begin
                if (started) begin
                    if (imem_ready) begin
                        state_d = S_DECODE;
                    end else if (wait_inc >= TIMEOUT_W) begin
                        state_d = S_FAULT;
                    end else begin
                        wait_d = wait_inc[7:0];
                    end
                end
            end
            S_DECODE: begin
                state_d = illegal_instruction ? S_FAULT : S_EXECUTE;
            end
            S_EXECUTE: begin
                if ((read_status != 2'b00) || (write_status != 2'b00)) begin
                    state_d = S_MEMORY;
                    wait_d  = '0;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (dmem_ready) begin
                    state_d = S_WRITEBACK;
                end else if (wait_inc >= TIMEOUT_W) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_inc[7:0];
                end
            end
            S_WRITEBACK: begin
                state_d = S_FETCH;
                wait_d  = '0;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    // Moore strobes decoded from state and captured flags (ir_write also
    // qualifies on imem_ready so the IR latches in the ready cycle).
    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        dmem_req   = 1'b0;
        dmem_write = 1'b0;
        rf_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = 1'b0;
        fault      = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = started;
                ir_write = started & imem_ready;
            end
            S_MEMORY: begin
                dmem_req   = is_load | is_store;
                dmem_write = is_store;
            end
            S_WRITEBACK: begin
                pc_write  = 1'b1;
                pc_source = is_branch & (is_jal | taken);
                rf_write  = ~is_store & (~is_branch | is_jal);
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: table of instruction vectors plus
// hand-written timeout, illegal-opcode, mid-memory reset and counter-wrap
// sequences; per-cycle expectations go through a scoreboard queue.
module tb_multicycle_controller;

    logic        clock;
    logic        reset;
    logic        imem_ready;
    logic        dmem_ready;
    logic [1:0]  read_status;
    logic [1:0]  write_status;
    logic [1:0]  write_back_type;
    logic        change_branch_instruction;
    logic        branch_taken;
    logic        illegal_instruction;
    logic        imem_req;
    logic        ir_write;
    logic        dmem_req;
    logic        dmem_write;
    logic        rf_write;
    logic        pc_write;
    logic        pc_source;
    logic        fault;
    logic [2:0]  state;
    logic [31:0] retired_count;

    multicycle_controller #(.TIMEOUT(4)) dut (
        .clock                     (clock),
        .reset                     (reset),
        .imem_ready                (imem_ready),
        .dmem_ready                (dmem_ready),
        .read_status               (read_status),
        .write_status              (write_status),
        .write_back_type           (write_back_type),
        .change_branch_instruction (change_branch_instruction),
        .branch_taken              (branch_taken),
        .illegal_instruction       (illegal_instruction),
        .imem_req                  (imem_req),
        .ir_write                  (ir_write),
        .dmem_req                  (dmem_req),
        .dmem_write                (dmem_write),
        .rf_write                  (rf_write),
        .pc_write                  (pc_write),
        .pc_source                 (pc_source),
        .fault                     (fault),
        .state                     (state),
        .retired_count             (retired_count)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic        ireq;
        logic        irw;
        logic        dreq;
        logic        dw;
        logic        rf;
        logic        pw;
        logic        src;
        logic        flt;
        logic [31:0] ret;
    } obs_t;

    typedef struct {
        string       name;
        logic [1:0]  rs;
        logic [1:0]  ws;
        logic [1:0]  wbt;
        logic        br;
        logic        tk;
        int unsigned delay;
        logic        mem;
        logic        dw;
        logic        rf;
        logic        src;
    } vec_t;

    obs_t        exp_q[$];
    vec_t        vecs[9];
    int          checks = 0;
    int          errors = 0;
    string       tag = "init";
    logic [31:0] exp_ret = 32'd0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic obs_t mk(input logic [2:0] st, input logic ireq, input logic irw,
                                input logic dreq, input logic dw, input logic rf,
                                input logic pw, input logic src, input logic flt,
                                input logic [31:0] r);
        obs_t o;
        o.st = st; o.ireq = ireq; o.irw = irw; o.dreq = dreq; o.dw = dw;
        o.rf = rf; o.pw = pw; o.src = src; o.flt = flt; o.ret = r;
        return o;
    endfunction

    // Scoreboard: compare one expected cycle per falling edge.
    always @(negedge clock) begin
        obs_t e;
        obs_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = mk(state, imem_req, ir_write, dmem_req, dmem_write, rf_write,
                   pc_write, pc_source, fault, retired_count);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got st=%0d ireq=%b irw=%b dreq=%b dw=%b rf=%b pw=%b src=%b flt=%b ret=%h, expected st=%0d ireq=%b irw=%b dreq=%b dw=%b rf=%b pw=%b src=%b flt=%b ret=%h",
                         tag, a.st, a.ireq, a.irw, a.dreq, a.dw, a.rf, a.pw, a.src, a.flt, a.ret,
                         e.st, e.ireq, e.irw, e.dreq, e.dw, e.rf, e.pw, e.src, e.flt, e.ret);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_cycle(input obs_t e);
        exp_q.push_back(e);
    endtask

    task automatic clear_inputs();
        imem_ready                = 1'b0;
        dmem_ready                = 1'b0;
        read_status               = 2'b00;
        write_status              = 2'b00;
        write_back_type           = 2'd0;
        change_branch_instruction = 1'b0;
        branch_taken              = 1'b0;
        illegal_instruction       = 1'b0;
    endtask

    function automatic logic [31:0] outs_word();
        return {21'd0, state, imem_req, ir_write, dmem_req, dmem_write,
                rf_write, pc_write, pc_source, fault};
    endfunction

    // Called at posedge+1; leaves the DUT in its first active FETCH cycle.
    task automatic reset_pulse(input string name);
        reset = 1'b1;
        clear_inputs();
        #1;
        chk({name, "_async_outs"}, outs_word(), 32'd0);
        chk({name, "_async_ret"}, retired_count, 32'd0);
        @(negedge clock);
        chk({name, "_held_outs"}, outs_word(), 32'd0);
        reset = 1'b0;
        #1;
        chk({name, "_released_outs"}, outs_word(), 32'd0);
        step();
        exp_ret = 32'd0;
    endtask

    task automatic run_instr(input vec_t v);
        tag                       = v.name;
        read_status               = v.rs;
        write_status              = v.ws;
        write_back_type           = v.wbt;
        change_branch_instruction = v.br;
        branch_taken              = v.tk;
        illegal_instruction       = 1'b0;
        imem_ready                = 1'b1;
        dmem_ready                = 1'b0;
        expect_cycle(mk(3'd0, 1, 1, 0, 0, 0, 0, 0, 0, exp_ret));
        step();
        imem_ready = 1'b0;
        expect_cycle(mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, exp_ret));
        step();
        expect_cycle(mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, exp_ret));
        step();
        if (v.mem) begin
            for (int unsigned k = 0; k <= v.delay; k++) begin
                dmem_ready = (k == v.delay);
                expect_cycle(mk(3'd3, 0, 0, 1, v.dw, 0, 0, 0, 0, exp_ret));
                step();
            end
        end
        dmem_ready = 1'b0;
        expect_cycle(mk(3'd4, 0, 0, 0, 0, v.rf, 1, v.src, 0, exp_ret));
        step();
        exp_ret = exp_ret + 32'd1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //             name     rs     ws     wbt   br  tk  dly mem dw  rf  src
        vecs[0] = '{"addi",   2'b00, 2'b00, 2'd0, 0, 0, 0, 0, 0, 1, 0};
        vecs[1] = '{"lw_d3",  2'b10, 2'b00, 2'd1, 0, 0, 3, 1, 0, 1, 0};
        vecs[2] = '{"beq_t",  2'b00, 2'b00, 2'd0, 1, 1, 0, 0, 0, 0, 1};
        vecs[3] = '{"beq_nt", 2'b00, 2'b00, 2'd0, 1, 0, 0, 0, 0, 0, 0};
        vecs[4] = '{"jal",    2'b00, 2'b00, 2'd2, 1, 0, 0, 0, 0, 1, 1};
        vecs[5] = '{"sw_d0",  2'b00, 2'b10, 2'd0, 0, 0, 0, 1, 1, 0, 0};
        vecs[6] = '{"sw_d2",  2'b00, 2'b01, 2'd0, 0, 1, 2, 1, 1, 0, 0};
        vecs[7] = '{"jal_tk", 2'b00, 2'b00, 2'd2, 1, 1, 0, 0, 0, 1, 1};
        vecs[8] = '{"lb_d1",  2'b01, 2'b00, 2'd1, 0, 0, 1, 1, 0, 1, 0};

        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clock);
        chk("reset_outs", outs_word(), 32'd0);
        chk("reset_ret", retired_count, 32'd0);
        reset = 1'b0;
        #1;
        chk("release_outs", outs_word(), 32'd0);
        step();

        for (int i = 0; i < 9; i++) begin
            run_instr(vecs[i]);
        end

        // Retirement counter wraps from all-ones to zero.
        tag = "wrap";
        clear_inputs();
        imem_ready = 1'b1;
        expect_cycle(mk(3'd0, 1, 1, 0, 0, 0, 0, 0, 0, exp_ret));
        step();
        imem_ready = 1'b0;
        force dut.retired_count = 32'hFFFF_FFFF;
        expect_cycle(mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF));
        step();
        release dut.retired_count;
        expect_cycle(mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF));
        step();
        expect_cycle(mk(3'd4, 0, 0, 0, 0, 1, 1, 0, 0, 32'hFFFF_FFFF));
        step();
        exp_ret = 32'd0;

        // Fetch timeout: four waiting cycles, then a sticky fault.
        tag = "timeout";
        for (int i = 0; i < 4; i++) begin
            expect_cycle(mk(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, exp_ret));
            step();
        end
        tag = "fault_sticky";
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_cycle(mk(3'd7, 0, 0, 0, 0, 0, 0, 0, 1, exp_ret));
            step();
        end
        reset_pulse("rst_fault");
        run_instr(vecs[0]);

        // Illegal opcode in decode faults without retiring.
        tag = "illegal";
        imem_ready = 1'b1;
        expect_cycle(mk(3'd0, 1, 1, 0, 0, 0, 0, 0, 0, exp_ret));
        step();
        imem_ready = 1'b0;
        illegal_instruction = 1'b1;
        expect_cycle(mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, exp_ret));
        step();
        illegal_instruction = 1'b0;
        for (int i = 0; i < 2; i++) begin
            expect_cycle(mk(3'd7, 0, 0, 0, 0, 0, 0, 0, 1, exp_ret));
            step();
        end
        reset_pulse("rst_illegal");

        // Reset asserted while a load waits in MEMORY.
        run_instr(vecs[0]);
        tag = "lw_midreset";
        read_status = 2'b10;
        write_back_type = 2'd1;
        imem_ready = 1'b1;
        expect_cycle(mk(3'd0, 1, 1, 0, 0, 0, 0, 0, 0, exp_ret));
        step();
        imem_ready = 1'b0;
        expect_cycle(mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, exp_ret));
        step();
        expect_cycle(mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, exp_ret));
        step();
        for (int i = 0; i < 2; i++) begin
            expect_cycle(mk(3'd3, 0, 0, 1, 0, 0, 0, 0, 0, exp_ret));
            step();
        end
        reset_pulse("rst_mem");
        run_instr(vecs[0]);

        @(negedge clock);
        #1;
        chk("queue_drain", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the maximum number of cycles to wait for a memory ready before faulting.
REQ-002 SHALL have port clock, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port imem_ready, input, 1, instruction memory data valid.
REQ-005 SHALL have port dmem_ready, input, 1, data memory access complete.
REQ-006 SHALL have port read_status, input, 2, decoder load size; 2'b00 means no load.
REQ-007 SHALL have port write_status, input, 2, decoder store size; 2'b00 means no store.
REQ-008 SHALL have port write_back_type, input, 2, decoder write-back kind: 0 normal, 1 load, 2 jal.
REQ-009 SHALL have port change_branch_instruction, input, 1, decoder branch/jump flag.
REQ-010 SHALL have port branch_taken, input, 1, ALU compare result (bit 0).
REQ-011 SHALL have port illegal_instruction, input, 1, decoder found an unsupported opcode.
REQ-012 SHALL have port imem_req, output, 1, instruction fetch request.
REQ-013 SHALL have port ir_write, output, 1, latch the fetched word into IR.
REQ-014 SHALL have port dmem_req, output, 1, data memory request.
REQ-015 SHALL have port dmem_write, output, 1, the data request is a store.
REQ-016 SHALL have port rf_write, output, 1, register file write enable.
REQ-017 SHALL have port pc_write, output, 1, PC update enable.
REQ-018 SHALL have port pc_source, output, 1: 0 selects PC+4, 1 selects the ALU target.
REQ-019 SHALL have port fault, output, 1, sticky error indicator.
REQ-020 SHALL have port state, output, 3, current FSM state code.
REQ-021 SHALL have port retired_count, output, 32, number of completed instructions.

Function
REQ-022 SHALL use these state codes: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, FAULT=7. Codes 5 and 6 SHALL go to FAULT.
REQ-023 SHALL drive outputs as Moore outputs decoded from state and registered flags; no output depends combinationally on a ready input except ir_write.
REQ-024 FETCH: SHALL assert imem_req; when imem_ready=1, SHALL pulse ir_write in that cycle and go to DECODE the next cycle.
REQ-025 DECODE: SHALL last exactly 1 cycle; if illegal_instruction=1, SHALL go to FAULT, otherwise to EXECUTE.
REQ-026 EXECUTE: SHALL last 1 cycle; SHALL capture is_load=(read_status!=0), is_store=(write_status!=0), is_jal=(write_back_type==2), is_branch=change_branch_instruction and taken=branch_taken into registers.
REQ-027 EXECUTE: if is_load or is_store, SHALL go to MEMORY, else to WRITEBACK.
REQ-028 MEMORY: SHALL hold dmem_req=1 and dmem_write=is_store until dmem_ready=1, then go to WRITEBACK.
REQ-029 WRITEBACK: SHALL last 1 cycle and assert pc_write=1.
REQ-030 WRITEBACK: SHALL set pc_source=1 iff is_branch and (is_jal or taken).
REQ-031 WRITEBACK: SHALL set rf_write=1 iff not is_store and (not is_branch or is_jal).
REQ-032 WRITEBACK: SHALL increment retired_count (mod 2^32, wrapping from FFFFFFFF to 0) and return to FETCH.
REQ-033 Minimum latency SHALL be 4 cycles for ALU/branch/jump instructions and 5 cycles for loads/stores, with ready asserted immediately.
REQ-034 SHALL keep an 8-bit wait counter: cleared on entry to FETCH/MEMORY, incremented each waiting cycle; if it reaches TIMEOUT without ready, SHALL go to FAULT.
REQ-035 If ready arrives in the same cycle the counter reaches TIMEOUT, ready SHALL win.
REQ-036 FAULT: SHALL be sticky until reset; SHALL assert fault=1 and deassert all other strobes; retired_count SHALL be frozen.
REQ-037 pc_write, rf_write and ir_write SHALL each be high for at most 1 cycle per instruction.

Reset
REQ-038 Asserting reset at any time, including mid-MEMORY, SHALL immediately force state=FETCH, retired_count=0, wait counter=0, all flags=0 and all outputs=0.
REQ-039 Outputs SHALL remain at these reset values until the first clock edge after reset is released.
REQ-040 The first cycle after reset is released SHALL be a FETCH cycle with imem_req=1.

Verification
REQ-041 ADDI, both readies tied high -> states 0,1,2,4,0; rf_write=1 and pc_write=1 in cycle 4; pc_source=0; retired_count=1.
REQ-042 LW with dmem_ready delayed 3 cycles -> MEMORY held 4 cycles with dmem_req=1 and dmem_write=0; then WRITEBACK with rf_write=1.
REQ-043 BEQ taken=1 -> pc_source=1, rf_write=0. BEQ taken=0 -> pc_source=0. JAL -> pc_source=1, rf_write=1. SW -> dmem_write=1, rf_write=0.
REQ-044 imem_ready held low with TIMEOUT=4 -> fault=1 after 4 wait cycles; a later imem_ready is ignored; a reset pulse restores state=0.
REQ-045 illegal_instruction=1 in DECODE -> FAULT and retired_count unchanged.
REQ-046 retired_count preset to FFFFFFFF by force, then one ADDI retires -> retired_count=0.
